// File: rtl/mxint_to_fixed.sv
// mxint_to_fixed
// Decodes one normalized MxInt block into BLOCK_SIZE signed fixed-point
// values. A block is BLOCK_SIZE signed mantissas plus one shared biased
// exponent. Each element's value is m * 2^(e - EBIAS - (MAN_WIDTH-2)).
// Outputs have OUT_WIDTH bits, OUT_FRAC_WIDTH of them fractional, and
// saturate symmetrically to +/-(2^(OUT_WIDTH-1)-1).
// The datapath is a two-stage valid/ready pipeline that runs at full
// throughput. A sticky saturation counter is provided for calibration.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   mdata_in[]      signed mantissas, one per element
//   edata_in        shared biased exponent
//   data_in_valid   input handshake
//   data_in_ready   input handshake
//   data_out[]      signed fixed-point results
//   data_out_valid  output handshake
//   data_out_ready  output handshake
//   sat_clear       synchronous clear of sat_count (wins over increments)
//   sat_count       running count of saturated elements, clamps at all-ones
module mxint_to_fixed #(
  parameter int MAN_WIDTH      = 8,
  parameter int EXP_WIDTH      = 4,
  parameter int BLOCK_SIZE     = 4,
  parameter int OUT_WIDTH      = 16,
  parameter int OUT_FRAC_WIDTH = 8,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [MAN_WIDTH-1:0] mdata_in [BLOCK_SIZE],
  input  logic        [EXP_WIDTH-1:0] edata_in,
  input  logic                        data_in_valid,
  output logic                        data_in_ready,
  output logic signed [OUT_WIDTH-1:0] data_out [BLOCK_SIZE],
  output logic                        data_out_valid,
  input  logic                        data_out_ready,
  input  logic                        sat_clear,
  output logic        [CNT_WIDTH-1:0] sat_count
);

  localparam int EBIAS   = 2**(EXP_WIDTH-1) - 1;
  localparam int IW      = MAN_WIDTH + OUT_WIDTH;
  // Wide enough to hold the whole exponent range plus both offsets, with sign.
  localparam int SHIFT_W = EXP_WIDTH + $clog2(IW + OUT_FRAC_WIDTH + 1) + 2;
  localparam int SAT_W   = $clog2(BLOCK_SIZE + 1);
  localparam int CW1     = CNT_WIDTH + 1;

  localparam logic signed [SHIFT_W-1:0] SHIFT_OFS =
    SHIFT_W'(OUT_FRAC_WIDTH - EBIAS - (MAN_WIDTH - 2));
  localparam logic signed [SHIFT_W-1:0] SHIFT_HI = SHIFT_W'(OUT_WIDTH);
  localparam logic signed [SHIFT_W-1:0] SHIFT_LO = SHIFT_W'(-MAN_WIDTH);

  localparam logic signed [IW-1:0] MAX_I =
    {{(MAN_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [IW-1:0] MIN_I = -MAX_I;
  localparam logic signed [OUT_WIDTH-1:0] MAX_O = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] MIN_O = -MAX_O;

  // Converts one element.
  // The return value is {saturated, value}.
  function automatic logic [OUT_WIDTH:0] convert(
    input logic signed [MAN_WIDTH-1:0] m,
    input logic signed [SHIFT_W-1:0]   sh
  );
    logic signed [IW-1:0]  ext;
    logic signed [IW-1:0]  wide;
    logic [SHIFT_W-1:0]    rsh;
    ext     = {{OUT_WIDTH{m[MAN_WIDTH-1]}}, m};
    rsh     = -sh;
    wide    = '0;
    convert = '0;
    if (m == '0) begin
      convert = '0;
    end else if (sh >= SHIFT_HI) begin
      convert = {1'b1, m[MAN_WIDTH-1] ? MIN_O : MAX_O};
    end else if (!sh[SHIFT_W-1]) begin
      // sh is below OUT_WIDTH here, so the shift fits in IW bits without loss.
      wide = ext <<< sh;
      if (wide > MAX_I) begin
        convert = {1'b1, MAX_O};
      end else if (wide < MIN_I) begin
        convert = {1'b1, MIN_O};
      end else begin
        convert = {1'b0, wide[OUT_WIDTH-1:0]};
      end
    end else if (sh <= SHIFT_LO) begin
      // Every mantissa bit is shifted out. Floor gives 0 or -1.
      convert = {1'b0, {OUT_WIDTH{m[MAN_WIDTH-1]}}};
    end else begin
      wide    = ext >>> rsh;
      convert = {1'b0, wide[OUT_WIDTH-1:0]};
    end
  endfunction

  logic                        s1_valid_q, s1_valid_d;
  logic signed [MAN_WIDTH-1:0] s1_man_q [BLOCK_SIZE];
  logic signed [MAN_WIDTH-1:0] s1_man_d [BLOCK_SIZE];
  logic signed [SHIFT_W-1:0]   s1_shift_q, s1_shift_d;
  logic                        s2_valid_q, s2_valid_d;
  logic signed [OUT_WIDTH-1:0] data_out_q [BLOCK_SIZE];
  logic signed [OUT_WIDTH-1:0] data_out_d [BLOCK_SIZE];
  logic [CNT_WIDTH-1:0]        sat_count_q, sat_count_d;

  logic                        s2_advance;
  logic                        s1_advance;
  logic                        in_fire;
  logic [OUT_WIDTH:0]          conv [BLOCK_SIZE];
  logic [SAT_W-1:0]            sat_inc;
  logic [CW1-1:0]              sat_sum;

  // Handshake.
  // Stage 2 frees up when it is empty or its output is taken.
  // Stage 1 drains into stage 2 whenever stage 2 frees up.
  always_comb begin
    s2_advance    = !s2_valid_q || data_out_ready;
    s1_advance    = s1_valid_q && s2_advance;
    data_in_ready = !s1_valid_q || s1_advance;
    in_fire       = data_in_valid && data_in_ready;
  end

  // Stage 1 captures the mantissas and the precomputed signed shift.
  always_comb begin
    s1_valid_d = data_in_ready ? data_in_valid : s1_valid_q;
    s1_man_d   = s1_man_q;
    s1_shift_d = s1_shift_q;
    if (in_fire) begin
      s1_man_d   = mdata_in;
      s1_shift_d = $signed({{(SHIFT_W-EXP_WIDTH){1'b0}}, edata_in}) + SHIFT_OFS;
    end
  end

  // Stage 2 converts, then registers the result.
  // The counter adds the block's saturations only when the block enters
  // this stage.
  always_comb begin
    s2_valid_d  = s2_advance ? s1_valid_q : s2_valid_q;
    data_out_d  = data_out_q;
    sat_inc     = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      conv[i] = convert(s1_man_q[i], s1_shift_q);
      sat_inc = sat_inc + SAT_W'(conv[i][OUT_WIDTH]);
      if (s1_advance) begin
        data_out_d[i] = conv[i][OUT_WIDTH-1:0];
      end
    end
    sat_sum     = {1'b0, sat_count_q} + CW1'(sat_inc);
    sat_count_d = sat_count_q;
    if (sat_clear) begin
      sat_count_d = '0;
    end else if (s1_advance) begin
      sat_count_d = sat_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sat_sum[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_shift_q  <= '0;
      s2_valid_q  <= 1'b0;
      sat_count_q <= '0;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        s1_man_q[i]   <= '0;
        data_out_q[i] <= '0;
      end
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_shift_q  <= s1_shift_d;
      s2_valid_q  <= s2_valid_d;
      sat_count_q <= sat_count_d;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        s1_man_q[i]   <= s1_man_d[i];
        data_out_q[i] <= data_out_d[i];
      end
    end
  end

  assign data_out       = data_out_q;
  assign data_out_valid = s2_valid_q;
  assign sat_count      = sat_count_q;

endmodule

// File: tb/tb_mxint_to_fixed.sv
// tb_mxint_to_fixed
// Directed, self-checking bench for mxint_to_fixed at default parameters.
// With EBIAS = 7 the shift is e - 5.
module tb_mxint_to_fixed;

  typedef logic signed [7:0]  man_blk_t [4];
  typedef logic signed [15:0] out_blk_t [4];

  logic               clk;
  logic               rst;
  logic signed [7:0]  mdata_in [4];
  logic        [3:0]  edata_in;
  logic               data_in_valid;
  logic               data_in_ready;
  logic signed [15:0] data_out [4];
  logic               data_out_valid;
  logic               data_out_ready;
  logic               sat_clear;
  logic        [15:0] sat_count;

  int errors = 0;
  int checks = 0;

  mxint_to_fixed dut (
    .clk           (clk),
    .rst           (rst),
    .mdata_in      (mdata_in),
    .edata_in      (edata_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .sat_clear     (sat_clear),
    .sat_count     (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    data_in_valid = 1'b0;
    data_out_ready = 1'b1;
    sat_clear = 1'b0;
    edata_in = 4'd0;
    for (int i = 0; i < 4; i++) mdata_in[i] = 8'sd0;
    repeat (2) @(negedge clk);
    checks++;
    if (data_out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_valid: got %b want 0", data_out_valid);
    end
    checks++;
    if (sat_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_sat_count: got %0d want 0", sat_count);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (data_out[i] !== 16'sd0) begin
        errors++;
        $display("[TB] FAIL reset_data_out[%0d]: got %0d want 0", i, data_out[i]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (data_in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b want 1", data_in_ready);
    end
  endtask

  task automatic test_convert(input string name, input man_blk_t m, input logic [3:0] e,
                              input out_blk_t exp_out, input int sat_delta);
    int sat_before;
    @(negedge clk);
    sat_before = int'(sat_count);
    mdata_in = m;
    edata_in = e;
    data_in_valid = 1'b1;
    data_out_ready = 1'b1;
    #1;
    checks++;
    if (data_in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_in_ready: got %b want 1", name, data_in_ready);
    end
    @(negedge clk);
    data_in_valid = 1'b0;
    checks++;
    if (data_out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_early_valid: got %b want 0", name, data_out_valid);
    end
    @(negedge clk);
    checks++;
    if (data_out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_latency_valid: got %b want 1", name, data_out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (data_out[i] !== exp_out[i]) begin
        errors++;
        $display("[TB] FAIL %s_data[%0d]: got %0d want %0d", name, i, data_out[i], exp_out[i]);
      end
    end
    checks++;
    if (int'(sat_count) !== sat_before + sat_delta) begin
      errors++;
      $display("[TB] FAIL %s_sat_count: got %0d want %0d", name, sat_count, sat_before + sat_delta);
    end
    @(negedge clk);
    checks++;
    if (data_out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_drain: got valid %b want 0", name, data_out_valid);
    end
  endtask

  task automatic test_back_to_back();
    out_blk_t snap;
    out_blk_t expv;
    int in_idx;
    int out_idx;
    int diff;
    in_idx = 0;
    out_idx = 0;
    for (int i = 0; i < 4; i++) snap[i] = 16'sd0;
    @(negedge clk);
    for (int cyc = 0; cyc < 40 && out_idx < 8; cyc++) begin
      data_out_ready = !(cyc >= 3 && cyc <= 6);
      if (in_idx < 8) begin
        mdata_in[0] = 8'(in_idx + 1);
        mdata_in[1] = 8'(-(in_idx + 1));
        mdata_in[2] = 8'(2 * in_idx);
        mdata_in[3] = 8'sd0;
        edata_in = 4'd7;
        data_in_valid = 1'b1;
      end else begin
        data_in_valid = 1'b0;
      end
      #1;
      if (cyc >= 3 && cyc <= 6) begin
        checks++;
        if (data_in_ready !== 1'b0 || data_out_valid !== 1'b1) begin
          errors++;
          $display("[TB] FAIL b2b_stall_cyc%0d: got in_ready %b out_valid %b want 0 1",
                   cyc, data_in_ready, data_out_valid);
        end
        if (cyc == 3) begin
          snap = data_out;
        end else begin
          diff = 0;
          for (int i = 0; i < 4; i++) if (data_out[i] !== snap[i]) diff++;
          checks++;
          if (diff != 0) begin
            errors++;
            $display("[TB] FAIL b2b_stable_cyc%0d: got %0d %0d want %0d %0d",
                     cyc, data_out[0], data_out[1], snap[0], snap[1]);
          end
        end
      end
      if (data_out_valid && data_out_ready) begin
        expv[0] = 16'(4 * (out_idx + 1));
        expv[1] = 16'(-4 * (out_idx + 1));
        expv[2] = 16'(8 * out_idx);
        expv[3] = 16'sd0;
        diff = 0;
        for (int i = 0; i < 4; i++) if (data_out[i] !== expv[i]) diff++;
        checks++;
        if (diff != 0) begin
          errors++;
          $display("[TB] FAIL b2b_out%0d: got %0d %0d %0d %0d want %0d %0d %0d %0d", out_idx,
                   data_out[0], data_out[1], data_out[2], data_out[3],
                   expv[0], expv[1], expv[2], expv[3]);
        end
        out_idx++;
      end
      if (data_in_valid && data_in_ready) in_idx++;
      @(negedge clk);
    end
    data_in_valid = 1'b0;
    data_out_ready = 1'b1;
    checks++;
    if (out_idx != 8) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d outputs want 8", out_idx);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (data_out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_no_dup: got valid %b want 0", data_out_valid);
    end
  endtask

  task automatic test_sat_counter();
    @(negedge clk);
    sat_clear = 1'b1;
    @(negedge clk);
    sat_clear = 1'b0;
    checks++;
    if (sat_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL sat_plain_clear: got %0d want 0", sat_count);
    end
    // Each block has four saturations: 16383 * 4 + 2 = 65534.
    mdata_in[0] = 8'sd64;
    mdata_in[1] = -8'sd64;
    mdata_in[2] = 8'sd127;
    mdata_in[3] = 8'h80;
    edata_in = 4'd15;
    data_out_ready = 1'b1;
    data_in_valid = 1'b1;
    repeat (16383) @(negedge clk);
    mdata_in[2] = 8'sd1;
    mdata_in[3] = -8'sd1;
    @(negedge clk);
    data_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sat_count !== 16'hFFFE) begin
      errors++;
      $display("[TB] FAIL sat_preload: got %0h want fffe", sat_count);
    end
    mdata_in[2] = 8'sd127;
    mdata_in[3] = 8'h80;
    for (int k = 0; k < 2; k++) begin
      data_in_valid = 1'b1;
      @(negedge clk);
      data_in_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (sat_count !== 16'hFFFF) begin
        errors++;
        $display("[TB] FAIL sat_clamp%0d: got %0h want ffff", k, sat_count);
      end
    end
    data_in_valid = 1'b1;
    @(negedge clk);
    data_in_valid = 1'b0;
    sat_clear = 1'b1;
    @(negedge clk);
    sat_clear = 1'b0;
    checks++;
    if (sat_count !== 16'd0 || data_out_valid !== 1'b1 || data_out[0] !== 16'sd32767) begin
      errors++;
      $display("[TB] FAIL sat_clear_collide: got cnt %0d valid %b d0 %0d want 0 1 32767",
               sat_count, data_out_valid, data_out[0]);
    end
    @(negedge clk);
    checks++;
    if (sat_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL sat_clear_hold: got %0d want 0", sat_count);
    end
  endtask

  task automatic test_reset_midflight();
    int late;
    late = 0;
    @(negedge clk);
    data_out_ready = 1'b0;
    mdata_in[0] = 8'sd64;
    mdata_in[1] = -8'sd64;
    mdata_in[2] = 8'sd1;
    mdata_in[3] = -8'sd1;
    edata_in = 4'd15;
    data_in_valid = 1'b1;
    repeat (2) @(negedge clk);
    data_in_valid = 1'b0;
    #1;
    checks++;
    if (data_out_valid !== 1'b1 || data_in_ready !== 1'b0 || sat_count !== 16'd2) begin
      errors++;
      $display("[TB] FAIL midrst_full: got valid %b in_ready %b cnt %0d want 1 0 2",
               data_out_valid, data_in_ready, sat_count);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (data_out_valid !== 1'b0 || sat_count !== 16'd0 || data_out[0] !== 16'sd0) begin
      errors++;
      $display("[TB] FAIL midrst_async: got valid %b cnt %0d d0 %0d want 0 0 0",
               data_out_valid, sat_count, data_out[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    data_out_ready = 1'b1;
    #1;
    checks++;
    if (data_in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_in_ready: got %b want 1", data_in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (data_out_valid !== 1'b0) late++;
    end
    checks++;
    if (late != 0) begin
      errors++;
      $display("[TB] FAIL midrst_no_output: got %0d valid cycles want 0", late);
    end
  endtask

  initial begin
    test_reset();
    test_convert("basic", '{8'sd64, -8'sd64, 8'sd32, 8'sd0}, 4'd7,
                 '{16'sd256, -16'sd256, 16'sd128, 16'sd0}, 0);
    test_convert("sat_hi", '{8'sd64, -8'sd64, 8'sd1, -8'sd1}, 4'd15,
                 '{16'sd32767, -16'sd32767, 16'sd1024, -16'sd1024}, 2);
    test_convert("floor", '{8'sd64, -8'sd1, 8'sd1, -8'sd64}, 4'd0,
                 '{16'sd2, -16'sd1, 16'sd0, -16'sd2}, 0);
    test_convert("edge", '{8'sd31, 8'sd32, -8'sd32, -8'sd31}, 4'd15,
                 '{16'sd31744, 16'sd32767, -16'sd32767, -16'sd31744}, 2);
    test_convert("unity", '{8'sd127, 8'h80, 8'sd1, -8'sd1}, 4'd5,
                 '{16'sd127, -16'sd128, 16'sd1, -16'sd1}, 0);
    test_back_to_back();
    test_sat_counter();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
